// File: rtl/vga_timing_gen_if.sv
// Video timing bundle between the raster generator and the pixel-address / colour stages.
// All members are driven by the generator from flops.
interface vga_timing_gen_if #(
  parameter int CW = 10
);
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          pixel_tick;
  logic          line_start;
  logic          frame_start;
  logic [7:0]    frame_count;

  modport master (
    output hsync, vsync, video_on, pixel_x, pixel_y,
           pixel_tick, line_start, frame_start, frame_count
  );

  modport slave (
    input  hsync, vsync, video_on, pixel_x, pixel_y,
           pixel_tick, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters with a pixel-clock divider,
// centred window decode with integer pixel replication, and line/frame strobes.
module vga_timing_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int WIN_W       = 320,
  parameter int WIN_H       = 240,
  parameter int SCALE_SHIFT = 0,
  parameter int CLK_DIV     = 1,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int CW          = 10
) (
  input  logic             clk_25mhz,
  input  logic             reset_n,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int WX0     = (H_DISPLAY - WIN_W) / 2;
  localparam int WY0     = (V_DISPLAY - WIN_H) / 2;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_DISPLAY + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_DISPLAY + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [CW-1:0] WX_FIRST = CW'(WX0);
  localparam logic [CW-1:0] WX_END   = CW'(WX0 + WIN_W);
  localparam logic [CW-1:0] WY_FIRST = CW'(WY0);
  localparam logic [CW-1:0] WY_END   = CW'(WY0 + WIN_H);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (WIN_W > H_DISPLAY || WIN_H > V_DISPLAY || WIN_W < 0 || WIN_H < 0 ||
      H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
      V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 || CLK_DIV < 1 ||
      ((H_TOTAL - 1) >> CW) != 0 || ((V_TOTAL - 1) >> CW) != 0) begin : g_bad_params
    $fatal(1, "vga_timing_gen: illegal parameter combination");
  end

  logic [DW-1:0] div_cnt_r;
  logic [CW-1:0] h_r;
  logic [CW-1:0] v_r;
  logic [7:0]    frame_cnt_r;

  logic          hsync_r;
  logic          vsync_r;
  logic          video_on_r;
  logic [CW-1:0] pixel_x_r;
  logic [CW-1:0] pixel_y_r;
  logic          pixel_tick_r;
  logic          line_start_r;
  logic          frame_start_r;
  logic [7:0]    frame_count_r;

  logic          hs_act_s;
  logic          vs_act_s;
  logic          in_x_s;
  logic          in_y_s;
  logic [CW-1:0] px_s;
  logic [CW-1:0] py_s;
  logic          pix_load_s;

  // Decode of the current raster position into sync, window and coordinate values.
  always_comb begin
    hs_act_s   = (h_r >= HS_FIRST) && (h_r <= HS_LAST);
    vs_act_s   = (v_r >= VS_FIRST) && (v_r <= VS_LAST);
    in_x_s     = (h_r >= WX_FIRST) && (h_r < WX_END);
    in_y_s     = (v_r >= WY_FIRST) && (v_r < WY_END);
    px_s       = in_x_s ? ((h_r - WX_FIRST) >> SCALE_SHIFT) : {CW{1'b0}};
    py_s       = in_y_s ? ((v_r - WY_FIRST) >> SCALE_SHIFT) : {CW{1'b0}};
    pix_load_s = (div_cnt_r == {DW{1'b0}});
  end

  // Divider and raster counters; the frame counter bumps on the wrap to (0,0).
  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      div_cnt_r   <= {DW{1'b0}};
      h_r         <= {CW{1'b0}};
      v_r         <= {CW{1'b0}};
      frame_cnt_r <= 8'd0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= {DW{1'b0}};
      if (h_r == H_LAST) begin
        h_r <= {CW{1'b0}};
        if (v_r == V_LAST) begin
          v_r         <= {CW{1'b0}};
          frame_cnt_r <= frame_cnt_r + 8'd1;
        end else begin
          v_r <= v_r + CW'(1'b1);
        end
      end else begin
        h_r <= h_r + CW'(1'b1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1'b1);
    end
  end

  // Output stage: captures the decode once per pixel, strobes fire only on that load.
  always_ff @(posedge clk_25mhz) begin
    if (!reset_n) begin
      hsync_r       <= ~HSYNC_POL;
      vsync_r       <= ~VSYNC_POL;
      video_on_r    <= 1'b0;
      pixel_x_r     <= {CW{1'b0}};
      pixel_y_r     <= {CW{1'b0}};
      pixel_tick_r  <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= 8'd0;
    end else if (pix_load_s) begin
      hsync_r       <= hs_act_s ? HSYNC_POL : ~HSYNC_POL;
      vsync_r       <= vs_act_s ? VSYNC_POL : ~VSYNC_POL;
      video_on_r    <= in_x_s && in_y_s;
      pixel_x_r     <= px_s;
      pixel_y_r     <= py_s;
      pixel_tick_r  <= 1'b1;
      line_start_r  <= (h_r == {CW{1'b0}});
      frame_start_r <= (h_r == {CW{1'b0}}) && (v_r == {CW{1'b0}});
      frame_count_r <= frame_cnt_r;
    end else begin
      pixel_tick_r  <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
    end
  end

  assign vid.hsync       = hsync_r;
  assign vid.vsync       = vsync_r;
  assign vid.video_on    = video_on_r;
  assign vid.pixel_x     = pixel_x_r;
  assign vid.pixel_y     = pixel_y_r;
  assign vid.pixel_tick  = pixel_tick_r;
  assign vid.line_start  = line_start_r;
  assign vid.frame_start = frame_start_r;
  assign vid.frame_count = frame_count_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: five parameter sets checked every cycle against a cycle-count
// raster model, plus a vector table and hand sequences for frame wrap and mid-line reset.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        von;
    logic [31:0] px;
    logic [31:0] py;
    logic        tick;
    logic        ls;
    logic        fs;
    logic [31:0] fc;
  } obs_t;

  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb, ww, wh, ss, div, hpol, vpol;
  } cfg_t;

  typedef struct {
    int   k;
    obs_t e;
  } vec_t;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  logic clk_25mhz = 1'b0;
  always #5 clk_25mhz = ~clk_25mhz;

  logic rstn_def, rstn_small, rstn_wrap, rstn_med;
  logic [4:0] rstn_v;
  assign rstn_v = {rstn_med, rstn_med, rstn_wrap, rstn_small, rstn_def};

  int   tests = 0;
  int   fails = 0;
  int   inst_fail [5] = '{0, 0, 0, 0, 0};
  int   kcnt [5] = '{-2, -2, -2, -2, -2};
  cfg_t cfg [5];
  vec_t tbl [17];

  vga_timing_gen_if #(.CW(10)) if_def ();
  vga_timing_gen_if #(.CW(4))  if_small ();
  vga_timing_gen_if #(.CW(4))  if_wrap ();
  vga_timing_gen_if #(.CW(7))  if_meds ();
  vga_timing_gen_if #(.CW(7))  if_medp ();

  vga_timing_gen u_def (.clk_25mhz(clk_25mhz), .reset_n(rstn_def), .vid(if_def));

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .V_DISPLAY(4),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .WIN_W(4), .WIN_H(2), .CLK_DIV(4), .CW(4))
    u_small (.clk_25mhz(clk_25mhz), .reset_n(rstn_small), .vid(if_small));

  vga_timing_gen #(.H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .V_DISPLAY(4),
    .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .WIN_W(4), .WIN_H(2), .CLK_DIV(1), .CW(4))
    u_wrap (.clk_25mhz(clk_25mhz), .reset_n(rstn_wrap), .vid(if_wrap));

  vga_timing_gen #(.H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4), .V_DISPLAY(48),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .WIN_W(32), .WIN_H(24), .SCALE_SHIFT(1), .CW(7))
    u_meds (.clk_25mhz(clk_25mhz), .reset_n(rstn_med), .vid(if_meds));

  vga_timing_gen #(.H_DISPLAY(64), .H_FRONT(4), .H_SYNC(8), .H_BACK(4), .V_DISPLAY(48),
    .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .WIN_W(32), .WIN_H(24), .CLK_DIV(2),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CW(7))
    u_medp (.clk_25mhz(clk_25mhz), .reset_n(rstn_med), .vid(if_medp));

  function automatic obs_t pack(logic hs, logic vs, logic von, logic [31:0] px,
                                logic [31:0] py, logic tick, logic ls, logic fs,
                                logic [31:0] fc);
    obs_t o;
    o = '{hs: hs, vs: vs, von: von, px: px, py: py, tick: tick, ls: ls, fs: fs, fc: fc};
    return o;
  endfunction

  obs_t obs_def, obs_small, obs_wrap, obs_meds, obs_medp;
  assign obs_def   = pack(if_def.hsync, if_def.vsync, if_def.video_on, 32'(if_def.pixel_x),
                          32'(if_def.pixel_y), if_def.pixel_tick, if_def.line_start,
                          if_def.frame_start, 32'(if_def.frame_count));
  assign obs_small = pack(if_small.hsync, if_small.vsync, if_small.video_on, 32'(if_small.pixel_x),
                          32'(if_small.pixel_y), if_small.pixel_tick, if_small.line_start,
                          if_small.frame_start, 32'(if_small.frame_count));
  assign obs_wrap  = pack(if_wrap.hsync, if_wrap.vsync, if_wrap.video_on, 32'(if_wrap.pixel_x),
                          32'(if_wrap.pixel_y), if_wrap.pixel_tick, if_wrap.line_start,
                          if_wrap.frame_start, 32'(if_wrap.frame_count));
  assign obs_meds  = pack(if_meds.hsync, if_meds.vsync, if_meds.video_on, 32'(if_meds.pixel_x),
                          32'(if_meds.pixel_y), if_meds.pixel_tick, if_meds.line_start,
                          if_meds.frame_start, 32'(if_meds.frame_count));
  assign obs_medp  = pack(if_medp.hsync, if_medp.vsync, if_medp.video_on, 32'(if_medp.pixel_x),
                          32'(if_medp.pixel_y), if_medp.pixel_tick, if_medp.line_start,
                          if_medp.frame_start, 32'(if_medp.frame_count));

  function automatic obs_t get_obs(int i);
    case (i)
      0:       return obs_def;
      1:       return obs_small;
      2:       return obs_wrap;
      3:       return obs_meds;
      default: return obs_medp;
    endcase
  endfunction

  // Expected outputs after the k-th edge since reset release (k < 0: in reset).
  function automatic obs_t model(cfg_t c, int k);
    int ht, vt, p, h, v, wx0, wy0, px, py;
    logic hs_on, vs_on, in_x, in_y, tick, ls;
    if (k < 0) return pack(logic'(c.hpol == 0), logic'(c.vpol == 0), F, 0, 0, F, F, F, 0);
    ht    = c.hd + c.hf + c.hs + c.hb;
    vt    = c.vd + c.vf + c.vs + c.vb;
    p     = k / c.div;
    h     = p % ht;
    v     = (p / ht) % vt;
    hs_on = (h >= c.hd + c.hf) && (h < c.hd + c.hf + c.hs);
    vs_on = (v >= c.vd + c.vf) && (v < c.vd + c.vf + c.vs);
    wx0   = (c.hd - c.ww) / 2;
    wy0   = (c.vd - c.wh) / 2;
    in_x  = (h >= wx0) && (h < wx0 + c.ww);
    in_y  = (v >= wy0) && (v < wy0 + c.wh);
    px    = in_x ? ((h - wx0) >> c.ss) : 0;
    py    = in_y ? ((v - wy0) >> c.ss) : 0;
    tick  = (k % c.div) == 0;
    ls    = tick && (h == 0);
    return pack(logic'(hs_on == (c.hpol != 0)), logic'(vs_on == (c.vpol != 0)), in_x && in_y,
                px, py, tick, ls, ls && (v == 0), (p / (ht * vt)) % 256);
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("hs=%b vs=%b von=%b px=%0d py=%0d tick=%b ls=%b fs=%b fc=%0d",
                     o.hs, o.vs, o.von, o.px, o.py, o.tick, o.ls, o.fs, o.fc);
  endfunction

  task automatic check_obs(input int i, input obs_t got, input obs_t exp, input string nm);
    tests++;
    if (got !== exp) begin
      fails++;
      inst_fail[i]++;
      $display("FAIL %s inst=%0d k=%0d got {%s} want {%s}", nm, i, kcnt[i], fmt(got), fmt(exp));
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", nm, got, exp);
    end
  endtask

  // Edges since reset release per instance; -1 means the last edge was a reset edge.
  always @(posedge clk_25mhz) begin
    for (int i = 0; i < 5; i++) begin
      if (!rstn_v[i]) kcnt[i] <= -1;
      else if (kcnt[i] != -2) kcnt[i] <= kcnt[i] + 1;
    end
  end

  // Continuous comparison of every instance against the raster model.
  always @(negedge clk_25mhz) begin
    for (int i = 0; i < 5; i++) begin
      if (kcnt[i] >= -1 && inst_fail[i] < 20) check_obs(i, get_obs(i), model(cfg[i], kcnt[i]), "model");
    end
  end

  // Random reset pulses on the medium rasters.
  initial begin
    rstn_med = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    rstn_med = 1'b1;
    forever begin
      repeat ($urandom_range(9000, 15000)) @(negedge clk_25mhz);
      rstn_med = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk_25mhz);
      rstn_med = 1'b1;
    end
  end

  initial begin
    int n;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 320, 240, 0, 1, 0, 0};
    cfg[1] = '{8, 1, 2, 1, 4, 1, 1, 1, 4, 2, 0, 4, 0, 0};
    cfg[2] = '{8, 1, 2, 1, 4, 1, 1, 1, 4, 2, 0, 1, 0, 0};
    cfg[3] = '{64, 4, 8, 4, 48, 2, 2, 3, 32, 24, 1, 1, 0, 0};
    cfg[4] = '{64, 4, 8, 4, 48, 2, 2, 3, 32, 24, 0, 2, 1, 1};
    // CLK_DIV=4 small raster: H_TOTAL 12, V_TOTAL 7, window h 2..5, v 1..2
    tbl[0]  = '{0,   pack(T, T, F, 0, 0, T, T, T, 0)};
    tbl[1]  = '{1,   pack(T, T, F, 0, 0, F, F, F, 0)};
    tbl[2]  = '{3,   pack(T, T, F, 0, 0, F, F, F, 0)};
    tbl[3]  = '{4,   pack(T, T, F, 0, 0, T, F, F, 0)};
    tbl[4]  = '{36,  pack(F, T, F, 0, 0, T, F, F, 0)};
    tbl[5]  = '{43,  pack(F, T, F, 0, 0, F, F, F, 0)};
    tbl[6]  = '{44,  pack(T, T, F, 0, 0, T, F, F, 0)};
    tbl[7]  = '{48,  pack(T, T, F, 0, 0, T, T, F, 0)};
    tbl[8]  = '{56,  pack(T, T, T, 0, 0, T, F, F, 0)};
    tbl[9]  = '{67,  pack(T, T, T, 2, 0, F, F, F, 0)};
    tbl[10] = '{76,  pack(T, T, F, 0, 0, T, F, F, 0)};
    tbl[11] = '{104, pack(T, T, T, 0, 1, T, F, F, 0)};
    tbl[12] = '{240, pack(T, F, F, 0, 0, T, T, F, 0)};
    tbl[13] = '{287, pack(T, F, F, 0, 0, F, F, F, 0)};
    tbl[14] = '{288, pack(T, T, F, 0, 0, T, T, F, 0)};
    tbl[15] = '{336, pack(T, T, F, 0, 0, T, T, T, 1)};
    tbl[16] = '{337, pack(T, T, F, 0, 0, F, F, F, 1)};

    rstn_def = 1'b0; rstn_small = 1'b0; rstn_wrap = 1'b0;
    repeat (3) @(negedge clk_25mhz);
    chk("pol_idle_hsync", 32'(obs_medp.hs), 0);
    chk("pol_idle_vsync", 32'(obs_medp.vs), 0);
    chk("def_idle_hsync", 32'(obs_def.hs), 1);
    rstn_def = 1'b1; rstn_small = 1'b1; rstn_wrap = 1'b1;

    @(negedge clk_25mhz);
    chk("first_tick", 32'(obs_def.tick), 1);
    chk("first_line_start", 32'(obs_def.ls), 1);
    chk("first_frame_start", 32'(obs_def.fs), 1);

    for (int i = 0; i < 17; i++) begin
      n = 0;
      while (kcnt[1] < tbl[i].k && n < 1000) begin
        @(negedge clk_25mhz);
        n++;
      end
      if (kcnt[1] != tbl[i].k) chk("tbl_wait", 32'(kcnt[1]), 32'(tbl[i].k));
      else check_obs(1, obs_small, tbl[i].e, $sformatf("tbl%0d", i));
    end

    n = 0;
    while (obs_wrap.fc != 255 && n < 30000) begin
      @(negedge clk_25mhz);
      n++;
    end
    chk("wrap_reach_255", obs_wrap.fc, 255);
    n = 0;
    while (obs_wrap.fc != 0 && n < 200) begin
      @(negedge clk_25mhz);
      n++;
    end
    chk("wrap_to_0", obs_wrap.fc, 0);
    chk("wrap_frame_start", 32'(obs_wrap.fs), 1);

    repeat (5) @(negedge clk_25mhz);
    rstn_wrap = 1'b0;
    @(negedge clk_25mhz);
    check_obs(2, obs_wrap, pack(T, T, F, 0, 0, F, F, F, 0), "midline_reset");
    rstn_wrap = 1'b1;
    @(negedge clk_25mhz);
    chk("post_reset_fs", 32'(obs_wrap.fs), 1);
    chk("post_reset_fc", obs_wrap.fc, 0);
    chk("post_reset_px", obs_wrap.px, 0);

    // default raster: hsync low from cycle 656 of the line for 96 cycles
    n = 0;
    while (obs_def.ls != 1'b1 && n < 1000) begin
      @(negedge clk_25mhz);
      n++;
    end
    n = 0;
    while (obs_def.hs != 1'b0 && n < 900) begin
      @(negedge clk_25mhz);
      n++;
    end
    chk("hsync_start", 32'(n), 656);
    n = 0;
    while (obs_def.hs == 1'b0 && n < 900) begin
      @(negedge clk_25mhz);
      n++;
    end
    chk("hsync_width", 32'(n), 96);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the fixed 640x480 / 320x240 controller in the display path and feeds the pixel-address and colour stages. Full-raster timings, active-window size, sync polarity, pixel-clock division and integer pixel replication are all set by parameters. All outputs are registered, and the block also provides line-start and frame-start strobes and a frame counter.

## Interface
Parameters:
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- WIN_W, 320, width of the window, centred horizontally in the active area
- WIN_H, 240, height of the window, centred vertically in the active area
- SCALE_SHIFT, 0, pixel replication; pixel_x/pixel_y = window offset >> SCALE_SHIFT
- CLK_DIV, 1, clock cycles per pixel (≥1)
- HSYNC_POL, 0, active level of hsync
- VSYNC_POL, 0, active level of vsync
- CW, 10, counter and coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk_25mhz  in  1  system clock; one rising edge per cycle
- reset_n  in  1  reset, synchronous and active-low
- hsync  out  1  horizontal sync, polarity set by HSYNC_POL
- vsync  out  1  vertical sync, polarity set by VSYNC_POL
- video_on  out  1  current pixel is inside the window
- pixel_x  out  CW  window-relative x after scaling; 0 outside the window
- pixel_y  out  CW  window-relative y after scaling; 0 outside the window
- pixel_tick  out  1  one-cycle strobe marking the cycle in which a new pixel's outputs appear
- line_start  out  1  one-cycle strobe with pixel_tick when h = 0
- frame_start  out  1  one-cycle strobe with pixel_tick when h = 0 and v = 0
- frame_count  out  8  count of completed frames; wraps 255→0

## Operation
- Totals: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Raster coordinates: h = 0 is the first active pixel and v = 0 is the first active line.
- Horizontal sync region: h in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. Vertical sync region: v in the analogous range.
- Window origin: WX0 = (H_DISPLAY-WIN_W)/2 and WY0 = (V_DISPLAY-WIN_H)/2, using integer division.
  - video_on = (WX0 ≤ h < WX0+WIN_W) and (WY0 ≤ v < WY0+WIN_H).
- pixel_x = (h-WX0)>>SCALE_SHIFT when h is inside the window's horizontal span, else 0. pixel_y uses the same rule with v.
  - Subtraction is unsigned CW-bit and is only evaluated inside the span.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps. With CLK_DIV = 1 the divider is constant 0.
- Pixel load: on each edge with div_cnt == 0, the output registers load the decode of the current (h, v). pixel_tick is 1 on that load and 0 on all other edges.
- Advance: on each edge with div_cnt == CLK_DIV-1, h increments.
  - At h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with that wrap, v wraps to 0 and frame_count increments.
- Parameter legality is checked at elaboration; a violation is a fatal error. Required: WIN_W ≤ H_DISPLAY, WIN_H ≤ V_DISPLAY, all porch and sync widths ≥ 1, CLK_DIV ≥ 1.

## Timing
- Reset (reset_n low at an edge) sets:
  - h = v = div_cnt = 0 and frame_count = 0
  - hsync = ~HSYNC_POL and vsync = ~VSYNC_POL
  - video_on, pixel_tick, line_start, frame_start all 0
  - pixel_x = pixel_y = 0
- Reset applied mid-frame takes effect on the same edge. No partial line is completed.
- First edge with reset_n high: outputs show pixel (0,0); pixel_tick = line_start = frame_start = 1; frame_count = 0.
- Output latency is one clk_25mhz cycle from counter value to output. The outputs stay stable for CLK_DIV cycles.
- Pixel period is CLK_DIV cycles, line period is H_TOTAL×CLK_DIV cycles, frame period is H_TOTAL×V_TOTAL×CLK_DIV cycles.
- frame_count updates on the same edge as the frame_start output that begins the next frame. It never updates on the first frame after reset.
- No glitches: every output comes directly from a flop.

## Test plan
- Defaults, release reset:
  - first edge: frame_start = line_start = pixel_tick = 1
  - hsync low for exactly 96 consecutive cycles starting at cycle 656 of each 800-cycle line
  - vsync low for 1600 cycles starting at line 490
- Defaults:
  - video_on first rises at line 120, cycle 160
  - pixel_x runs 0..319 with video_on high for 320 cycles per line, across 240 lines
  - pixel_x = pixel_y = 0 everywhere outside the window
- CLK_DIV = 4, small raster (H 8/1/2/1, V 4/1/1/1, window 4x2):
  - pixel_tick every 4th cycle
  - outputs stable for 4 cycles
  - line = 48 cycles, frame = 336 cycles
- SCALE_SHIFT = 1, defaults: pixel_x holds each value 0..159 for 2 pixels and pixel_y each 0..119 for 2 lines.
- HSYNC_POL = VSYNC_POL = 1: sync pulses active-high over the same intervals; idle level 0 during and after reset.
- Small raster, 260 frames: frame_count reaches 255 and then wraps to 0. Then assert reset_n low mid-line for 1 cycle; on the next edge outputs equal the reset values, and the following edge shows frame_start = 1 with frame_count = 0.
